// File: rtl/cpu_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, writeback FSM states and access-size decode.
package cpu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WB     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Undefined width codes fall back to word accesses.
  function automatic acc_size_e f3_size(input logic [2:0] f3);
    acc_size_e sz;
    case (f3)
      F3_LB, F3_LBU: sz = SZ_BYTE;
      F3_LH, F3_LHU: sz = SZ_HALF;
      default:       sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment: selects the addressed byte/half lane of the memory word and sign/zero extends it.
// Latency: combinational. Backpressure: none.
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_writeback_unit.sv
// Load/store + writeback stage: one data-memory access over req/ack, then a one-cycle register-file write (MISALIGN_TRAP_EN adds misaligned traps).
// Latency: non-memory op writes back one cycle after accept; memory op one cycle after mem_ack, or after ACK_TIMEOUT cycles with bus_err.
// Backpressure: ex_ready only in IDLE; a single op is in flight and execute stalls until its writeback cycle has passed.
module mem_writeback_unit
  import cpu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write_in,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] data_to_reg,
  output logic        bus_err,
  output logic        misalign
);

  localparam int            TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);

  state_e        state, state_nxt;
  logic          accept, is_mem, st_in, ld_in, trap;
  acc_size_e     size_in;
  logic [3:0]    strb_in;
  logic [31:0]   wdata_in;
  logic [31:0]   ext_data;

  logic [TW-1:0] timer;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q;
  logic          ld_q, we_q, rw_q, err_q, mis_q;
  logic [4:0]    rd_q;
  logic [31:0]   data_q, addr_q, wdata_q;
  logic [3:0]    wstrb_q;

  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid & ex_ready;
  assign is_mem   = mem_read | mem_write;
  assign st_in    = mem_write;
  assign ld_in    = mem_read & ~mem_write;
  assign size_in  = f3_size(funct3);

`ifdef MISALIGN_TRAP_EN
  assign trap = is_mem & (((size_in == SZ_HALF) & alu_result[0]) |
                          ((size_in == SZ_WORD) & (alu_result[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  // Without trapping, offending low address bits simply don't steer the lanes.
  always_comb begin
    strb_in  = 4'hF;
    wdata_in = store_data;
    case (size_in)
      SZ_BYTE: begin
        strb_in  = 4'b0001 << alu_result[1:0];
        wdata_in = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        strb_in  = 4'b0011 << {alu_result[1], 1'b0};
        wdata_in = {2{store_data[15:0]}};
      end
      default: begin
        strb_in  = 4'hF;
        wdata_in = store_data;
      end
    endcase
  end

  load_extend u_load_extend (
    .rdata   (mem_rdata),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .data    (ext_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (is_mem & ~trap) ? ACCESS : WB;
      ACCESS:  if (mem_ack || (timer == TMR_LAST)) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer   <= '0;
      f3_q    <= '0;
      lo_q    <= '0;
      ld_q    <= 1'b0;
      we_q    <= 1'b0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      timer  <= '0;
      f3_q   <= funct3;
      lo_q   <= alu_result[1:0];
      ld_q   <= ld_in;
      rw_q   <= reg_write_in;
      rd_q   <= rd;
      data_q <= alu_result;
      err_q  <= 1'b0;
      mis_q  <= trap;
      if (is_mem & ~trap) begin
        we_q    <= st_in;
        addr_q  <= {alu_result[31:2], 2'b00};
        wdata_q <= wdata_in;
        wstrb_q <= st_in ? strb_in : 4'h0;
      end
    end else if (state == ACCESS) begin
      // An ack arriving in the final timer cycle still completes normally.
      if (mem_ack) begin
        if (ld_q) data_q <= ext_data;
      end else if (timer == TMR_LAST) begin
        err_q <= 1'b1;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

  assign mem_req     = (state == ACCESS);
  assign mem_we      = (state == ACCESS) & we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;

  assign wb_valid    = (state == WB);
  assign reg_write   = wb_valid & rw_q & (rd_q != 5'd0) & ~err_q & ~mis_q;
  assign wb_rd       = rd_q;
  assign data_to_reg = data_q;
  assign bus_err     = wb_valid & err_q;

`ifdef MISALIGN_TRAP_EN
  assign misalign = wb_valid & mis_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_writeback_unit.sv
// Bench for mem_writeback_unit: random op/latency stream against an op-level timeline model, plus fixed scenarios.
module tb_mem_writeback_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_result, store_data;
  logic [2:0]  funct3;
  logic        mem_read, mem_write, reg_write_in;
  logic [4:0]  rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid, reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] data_to_reg;
  logic        bus_err, misalign;

  always #5 clk = ~clk;

  mem_writeback_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .store_data(store_data), .funct3(funct3),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write_in(reg_write_in), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .reg_write(reg_write), .wb_rd(wb_rd), .data_to_reg(data_to_reg),
    .bus_err(bus_err), .misalign(misalign)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, passed = 0;

  // Expected timeline of the op in flight, in negedge sample indices.
  int s_cyc = -10, req_from = 0, req_to = -1, wb_cyc = -1, ack_cyc = -1;
  logic [31:0] e_addr, e_wdata, e_data, rdw_plan;
  logic [3:0]  e_strb;
  logic        e_we, e_rw, e_err, e_mis;
  logic [4:0]  e_rd;
  bit          chk_en = 1'b0;

  logic [31:0] last_data, first_addr, first_wdata;
  logic [3:0]  first_strb;
  logic        last_rw, last_err, last_mis;
  int          last_wb = 0, req_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int sz(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80)   ? b - 32'h100   : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin : compare
    bit busy, in_req, wbv;
    if (chk_en) begin
      busy   = (cyc > s_cyc) && (cyc <= wb_cyc);
      in_req = (cyc >= req_from) && (cyc <= req_to);
      wbv    = (cyc == wb_cyc);
      chk("ex_ready", ex_ready, !busy);
      chk("mem_req", mem_req, in_req);
      if (mem_req) req_cnt++;
      if (in_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", mem_we, e_we);
        chk("mem_wstrb", mem_wstrb, e_strb);
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        if (cyc == req_from) begin
          first_addr  = mem_addr;
          first_wdata = mem_wdata;
          first_strb  = mem_wstrb;
        end
      end
      chk("wb_valid", wb_valid, wbv);
      if (wbv) begin
        chk("reg_write", reg_write, e_rw);
        chk("bus_err", bus_err, e_err);
        chk("misalign", misalign, e_mis);
        chk("wb_rd", wb_rd, e_rd);
        if (!e_err && !e_mis) chk("data_to_reg", data_to_reg, e_data);
        last_data = data_to_reg;
        last_rw   = reg_write;
        last_err  = bus_err;
        last_mis  = misalign;
        last_wb   = cyc;
      end else begin
        chk("idle_pulses", {29'd0, reg_write, bus_err, misalign}, 32'd0);
      end
    end
  end

  // One clock: junk ex_valid while busy, memory responder (planned ack or stale acks).
  task automatic step();
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    if (!ex_ready && $urandom_range(0, 3) == 0) begin
      ex_valid     = 1'b1;
      alu_result   = $urandom;
      store_data   = $urandom;
      funct3       = 3'($urandom);
      mem_read     = 1'($urandom);
      mem_write    = 1'($urandom);
      reg_write_in = 1'($urandom);
      rd           = 5'($urandom);
    end
    if (cyc >= req_from && cyc <= req_to) begin
      mem_ack   = (cyc == ack_cyc);
      mem_rdata = (cyc == ack_cyc) ? rdw_plan : $urandom;
    end else begin
      mem_ack   = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                       input logic mr, input logic mw, input logic rwi, input logic [4:0] rdn,
                       input int d, input logic [31:0] rdw);
    int guard;
    bit is_mem, ld, mis;
    int k, n;
    guard = 0;
    while (!ex_ready) begin
      step();
      guard++;
      if (guard > 100) begin chk("ready_bound", 32'd0, 32'd1); return; end
    end
    ex_valid = 1'b1; alu_result = a; store_data = sd; funct3 = f3;
    mem_read = mr; mem_write = mw; reg_write_in = rwi; rd = rdn;
    is_mem = mr | mw;
    ld     = mr & ~mw;
    n      = sz(f3);
`ifdef MISALIGN_TRAP_EN
    mis = is_mem && ((a % n) != 0);
`else
    mis = 1'b0;
`endif
    req_cnt  = 0;
    rdw_plan = rdw;
    s_cyc    = cyc;
    e_err    = 1'b0;
    if (is_mem && !mis) begin
      k        = (d < TO) ? d + 1 : TO;
      e_err    = (d >= TO);
      ack_cyc  = (d < TO) ? s_cyc + 1 + d : -1;
      req_from = s_cyc + 1;
      req_to   = s_cyc + k;
      wb_cyc   = s_cyc + k + 1;
    end else begin
      ack_cyc  = -1;
      req_from = 0;
      req_to   = -1;
      wb_cyc   = s_cyc + 1;
    end
    e_addr  = {a[31:2], 2'b00};
    e_we    = mw;
    e_strb  = !mw ? 4'h0 : (n == 1) ? 4'(1 << a[1:0]) : (n == 2) ? 4'(3 << (a[1:0] & 2'b10)) : 4'hF;
    e_wdata = (n == 1) ? (sd & 32'hFF) * 32'h0101_0101 : (n == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
    e_data  = (ld && !e_err) ? model_load(rdw, a[1:0], f3) : a;
    e_mis   = mis;
    e_rd    = rdn;
    e_rw    = rwi && (rdn != 5'd0) && !e_err && !mis;
    guard = 0;
    while (cyc <= wb_cyc) begin
      step();
      guard++;
      if (guard > 100) begin chk("wb_bound", 32'd0, 32'd1); return; end
    end
  endtask

  initial begin
    int kind, r, d;
    logic mr, mw;
    reset = 1'b0; ex_valid = 1'b0; alu_result = '0; store_data = '0; funct3 = '0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write_in = 1'b0; rd = '0;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_ctrl", {26'd0, mem_req, mem_we, wb_valid, reg_write, bus_err, misalign}, 32'd0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_data", data_to_reg, 0);
    chk("rst_rd", wb_rd, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk_en = 1'b1;

    // ALU op
    issue(32'h1234_5678, 32'h0, 3'b000, 0, 0, 1, 5'd5, 0, 32'h0);
    chk("alu_data", last_data, 32'h1234_5678);
    chk("alu_rw", last_rw, 1);
    chk("alu_latency", last_wb - s_cyc, 1);
    // Load extension
    issue(32'h0000_1002, 32'h0, 3'b000, 1, 0, 1, 5'd4, 2, 32'h0080_0000);
    chk("lb_data", last_data, 32'hFFFF_FF80);
    issue(32'h0000_1002, 32'h0, 3'b100, 1, 0, 1, 5'd4, 1, 32'h0080_0000);
    chk("lbu_data", last_data, 32'h0000_0080);
    issue(32'h0000_1002, 32'h0, 3'b101, 1, 0, 1, 5'd4, 0, 32'h8001_0000);
    chk("lhu_data", last_data, 32'h0000_8001);
    // Byte store, ack on the fourth request cycle
    issue(32'h0000_0103, 32'h0000_00AB, 3'b000, 0, 1, 0, 5'd0, 3, 32'h0);
    chk("sb_addr", first_addr, 32'h0000_0100);
    chk("sb_strb", first_strb, 4'b1000);
    chk("sb_wdata", first_wdata, 32'hABAB_ABAB);
    chk("sb_rw", last_rw, 0);
    chk("sb_req_cycles", req_cnt, 4);
    // Timeout, and ack on the final timeout cycle
    issue(32'h0000_0040, 32'h0, 3'b010, 1, 0, 1, 5'd9, 20, 32'h0);
    chk("to_err", last_err, 1);
    chk("to_rw", last_rw, 0);
    chk("to_req_cycles", req_cnt, 16);
    chk("to_ready", ex_ready, 1);
    issue(32'h0000_0044, 32'h0, 3'b010, 1, 0, 1, 5'd9, 15, 32'h5A5A_0F0F);
    chk("late_ack_err", last_err, 0);
    chk("late_ack_data", last_data, 32'h5A5A_0F0F);
    chk("late_ack_req_cycles", req_cnt, 16);
    // Misaligned word load
    issue(32'h0000_0102, 32'h0, 3'b010, 1, 0, 1, 5'd3, 0, 32'hCAFE_F00D);
`ifdef MISALIGN_TRAP_EN
    chk("mis_pulse", last_mis, 1);
    chk("mis_no_req", req_cnt, 0);
    chk("mis_rw", last_rw, 0);
`else
    chk("mis_addr", first_addr, 32'h0000_0100);
    chk("mis_req_cycles", req_cnt, 1);
    chk("mis_data", last_data, 32'hCAFE_F00D);
`endif

    // Reset during an access, then stale acks
    chk_en = 1'b0;
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; alu_result = 32'h200;
    funct3 = 3'b010; rd = 5'd7; reg_write_in = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_req", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_req_drop", mem_req, 0);
    chk("rst_mid_ready", ex_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_wb", wb_valid, 0);
      chk("rst_idle", {30'd0, ex_ready, mem_req}, 32'd2);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    s_cyc = cyc; wb_cyc = -1; req_from = 0; req_to = -1; ack_cyc = -1;
    chk_en = 1'b1;
    issue(32'h0000_0300, 32'h0, 3'b010, 1, 0, 1, 5'd0, 1, 32'h7777_8888);
    chk("rd0_rw", last_rw, 0);
    chk("rd0_data", last_data, 32'h7777_8888);

    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 3);
      mr   = (kind == 1) || (kind == 3);
      mw   = (kind == 2) || (kind == 3);
      r    = $urandom_range(0, 9);
      d    = (r < 7) ? $urandom_range(0, 5) : $urandom_range(14, 18);
      issue($urandom, $urandom, 3'($urandom), mr, mw, 1'($urandom),
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), d, $urandom);
      repeat ($urandom_range(0, 2)) step();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
